// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  startE,
  input  logic                  flushE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] rd1E,
  input  logic [DATA_WIDTH-1:0] rd2E,
  input  logic [4:0]            RdE,
  output logic                  busyE,
  output logic                  doneE,
  output logic [DATA_WIDTH-1:0] ResultE,
  output logic [4:0]            RdM
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           f3_q, f3_d;
  logic [4:0]           rd_q, rd_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [W-1:0]         res_q, res_d;
  logic [4:0]           rdm_q, rdm_d;

  logic         a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_zero, ovf;
  logic         accept;

  assign a_sgn = ~funct3E[2] ? (funct3E[1:0] != 2'b11) : ~funct3E[0];
  assign b_sgn = ~funct3E[2] ? ~funct3E[1] : ~funct3E[0];
  assign a_neg = a_sgn & rd1E[W-1];
  assign b_neg = b_sgn & rd2E[W-1];
  assign a_mag = a_neg ? -rd1E : rd1E;
  assign b_mag = b_neg ? -rd2E : rd2E;

  assign div_zero = funct3E[2] & (rd2E == '0);
  assign ovf = funct3E[2] & ~funct3E[0]
             & (rd1E == MIN) & (&rd2E);
  assign accept = (state_q == S_IDLE) & startE & ~flushE;

  // Multiply step: add multiplicand into upper half, shift right
  logic [W:0]     msum;
  logic [2*W-1:0] mstep;
  assign msum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_q};
  assign mstep = acc_q[0] ? {msum, acc_q[W-1:1]}
                          : {1'b0, acc_q[2*W-1:1]};

  // Divide step: acc holds {remainder, dividend/quotient}
  logic [W:0]     dsh;
  logic           dge;
  logic [W-1:0]   ddiff;
  logic [2*W-1:0] dstep;
  assign dsh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign dge   = dsh >= {1'b0, b_q};
  assign ddiff = dsh[W-1:0] - b_q;
  assign dstep = {dge ? ddiff : dsh[W-1:0], acc_q[W-2:0], dge};

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, remv, sel;
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign remv = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    sel = '0;
    unique case (1'b1)
      f3_q == 3'b000:                   sel = prod[W-1:0];
      ~f3_q[2] & (f3_q[1:0] != 2'b00): sel = prod[2*W-1:W];
      f3_q[2] & ~f3_q[1]:               sel = quo;
      f3_q[2] & f3_q[1]:                sel = remv;
      default:                          sel = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    res_d   = res_q;
    rdm_d   = rdm_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d  = funct3E;
          rd_d  = RdE;
          a_d   = a_mag;
          b_d   = b_mag;
          cnt_d = CNT_WIDTH'(W-1);
          neg_d = (funct3E[2] & funct3E[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d = funct3E[2] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
          state_d = S_CALC;
          // Special cases preload the final answer and skip iteration
          if (div_zero) begin
            neg_d   = 1'b0;
            acc_d   = {rd1E, {W{1'b1}}};
            state_d = S_FIX;
          end else if (ovf) begin
            neg_d   = 1'b0;
            acc_d   = {{W{1'b0}}, MIN};
            state_d = S_FIX;
          end
        end
      end
      S_CALC: begin
        acc_d = f3_q[2] ? dstep : mstep;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (flushE) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flushE) begin
          res_d   = sel;
          rdm_d   = rd_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      rdm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      rdm_q   <= rdm_d;
    end
  end

  assign busyE   = (state_q == S_CALC) | (state_q == S_FIX) | accept;
  assign doneE   = (state_q == S_DONE);
  assign ResultE = res_q;
  assign RdM     = rdm_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes forwarded operands and RdE from the decode/execute pipeline register.
- While it computes, it drives a stall to the hazard unit.
- It returns a result and destination register to the execute/memory pipe with a one-cycle done pulse.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and ≥ 4.
CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
startE  input  1  M-extension instruction valid in execute this cycle
flushE  input  1  abort current operation (branch/jump flush)
funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rd1E  input  DATA_WIDTH  operand A (rs1, post-forwarding)
rd2E  input  DATA_WIDTH  operand B (rs2, post-forwarding)
RdE  input  5  destination register
busyE  output  1  stall request to hazard unit
doneE  output  1  result valid, single-cycle pulse
ResultE  output  DATA_WIDTH  operation result
RdM  output  5  destination register of completed operation

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (asynchronous, rst_n low): state=IDLE; doneE=0; ResultE=0; RdM=0; counter=0; all internal registers cleared. Reset mid-operation discards the operation with no done.
- IDLE, startE=1, flushE=0:
  - Latch funct3E and RdE.
  - Latch operand magnitudes: signed operands are negated when negative. MULH treats both operands as signed; MULHSU treats only A as signed; the U variants treat neither as signed.
  - Record result sign: product sign, quotient sign = A^B, remainder sign = sign of A.
  - Counter = DATA_WIDTH-1.
  - Next state is CALC, or FIX if a special case applies.
- Special cases, detected at start, go IDLE→FIX:
  - Divide by zero: quotient = all ones; remainder = A unmodified.
  - Signed overflow (DIV/REM with A = MIN, B = −1): quotient = MIN; remainder = 0.
- CALC: one iteration per cycle, exactly DATA_WIDTH cycles; leaves for FIX when counter = 0.
  - Multiply: shift-add into a 2×DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract over quotient and remainder registers.
- FIX: one cycle.
  - Apply two's-complement sign correction to the 2×DATA_WIDTH product, quotient or remainder.
  - Select the low half (MUL), high half (MULH/MULHSU/MULHU), quotient or remainder.
  - Register the selection into ResultE; RdM <= latched Rd.
- DONE: doneE=1 for exactly this cycle; next state IDLE.
- Latency:
  - Normal operation: doneE is high in cycle DATA_WIDTH+2 after the start edge (cycle 34 for 32-bit).
  - Special case: doneE is high in cycle 2.
- busyE, combinational:
  - High when state ∈ {CALC, FIX}.
  - High when state = IDLE with startE=1 and flushE=0.
  - Low in DONE, so the stalled instruction advances while doneE=1.
- ResultE/RdM hold their value until the next FIX; doneE qualifies them.
- startE outside IDLE is ignored; there is no queuing.
- flushE in CALC or FIX: next state is IDLE, no doneE, ResultE unchanged, busyE low the following cycle.
- flushE in DONE: doneE still pulses and the downstream pipe discards it.
- startE together with flushE in IDLE: start is not accepted.
- Arithmetic is modulo 2^DATA_WIDTH; no exceptions are raised.

Test Plan:
1. MUL 0x00000007 × 0xFFFFFFFD, Rd=5:
   - busyE high from the start cycle through cycle 33.
   - doneE pulses at cycle 34 with ResultE=0xFFFFFFEB and RdM=5.
2. MULH 0x80000000 × 0x80000000 → ResultE=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU same operands → 2.
4. Special cases, each with doneE at cycle 2:
   - DIVU 0x1234 / 0 → 0xFFFFFFFF.
   - REMU same operands → 0x1234.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM same operands → 0.
5. Abort and reset:
   - Start DIV, assert flushE at cycle 10 → no doneE ever; busyE low at cycle 11; a new MUL started at cycle 12 completes at cycle 46.
   - Drop rst_n low at cycle 20 → outputs zero immediately.
6. Assert startE continuously while busy → only one operation is accepted.
   - Back-to-back operations: a second start in the cycle after DONE is accepted, and its doneE follows DATA_WIDTH+2 cycles later.
